// File: rtl/rr_mux_arb.sv
// N-channel multiplexer with fixed-select or round-robin arbitration
// feeding a single valid/ready output register stage.
module rr_mux_arb #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4,
    parameter int unsigned SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_src,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] ch_data [N];
    logic             load_en;
    logic             gnt_vld;
    logic [SEL_W-1:0] gnt_idx;
    logic [SEL_W-1:0] rr_idx;
    logic [WIDTH-1:0] gnt_data;
    logic [SEL_W-1:0] ptr;

    for (genvar g = 0; g < int'(N); g++) begin : g_unpack
        assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end

    // Output stage can take a new word when empty or being drained.
    assign load_en = !out_valid || out_ready;

    // Grant selection; round-robin searches upward from ptr+1 with wrap.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        rr_idx  = '0;
        if (!mode) begin
            if ((32'(sel) < N) && in_valid[sel]) begin
                gnt_vld = 1'b1;
                gnt_idx = sel;
            end
        end else begin
            for (int unsigned k = 1; k <= N; k++) begin
                rr_idx = SEL_W'((32'(ptr) + k) % N);
                if (!gnt_vld && in_valid[rr_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = rr_idx;
                end
            end
        end
    end

    assign gnt_data = ch_data[gnt_idx];

    // Accept strobe back to the granted channel only.
    always_comb begin
        in_ready = '0;
        if (!rst && load_en && gnt_vld) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= SEL_W'(N - 1);
        end else if (load_en) begin
            out_valid <= gnt_vld;
            if (gnt_vld) begin
                out_data <= gnt_data;
                out_src  <= gnt_idx;
                ptr      <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_rr_mux_arb.sv
// Directed bench for rr_mux_arb (N=4, WIDTH=32) with hand-computed expectations.
module tb_rr_mux_arb;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned N     = 4;
    localparam int unsigned SEL_W = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N*WIDTH-1:0]   in_data;
    logic [N-1:0]         in_valid;
    logic [N-1:0]         in_ready;
    logic                 mode;
    logic [SEL_W-1:0]     sel;
    logic [WIDTH-1:0]     out_data;
    logic [SEL_W-1:0]     out_src;
    logic                 out_valid;
    logic                 out_ready;

    int total  = 0;
    int passed = 0;
    logic [WIDTH-1:0] hold_data;
    logic [SEL_W-1:0] exp_src;

    rr_mux_arb #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel(sel),
        .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int unsigned ch, input logic [WIDTH-1:0] val);
        in_data[ch*WIDTH +: WIDTH] = val;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_valid = '0; mode = 1'b0; sel = '0; out_ready = 1'b0;
        tick(); tick();
        // Reset: outputs cleared, no ready even with requests pending
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        #1;
        check("rst_in_ready", in_ready, 4'b0000);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_out_src", out_src, 2'd0);
        tick();

        // Fixed mode, sel=2, first grant right after reset release
        rst = 1'b0; mode = 1'b0; sel = 2'd2; in_valid = 4'b0100;
        set_ch(0, 32'h11111111); set_ch(1, 32'h22222222);
        set_ch(2, 32'hDEADBEEF); set_ch(3, 32'h44444444);
        #1;
        check("fix_in_ready", in_ready, 4'b0100);
        tick();
        check("fix_out_valid", out_valid, 1'b1);
        check("fix_out_data", out_data, 32'hDEADBEEF);
        check("fix_out_src", out_src, 2'd2);

        // Round-robin from reset: sources 0,1,2,3,0 back to back
        rst = 1'b1; tick();
        check("rst2_out_valid", out_valid, 1'b0);
        rst = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_ch(i, 32'hA0 + 32'(i));
        exp_src = 2'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rr_out_valid", out_valid, 1'b1);
            check("rr_out_src", out_src, exp_src);
            check("rr_out_data", out_data, 32'hA0 + 32'(exp_src));
            exp_src = exp_src + 2'd1;
        end

        // Force ptr=3 by a fixed grant of ch3, then wrap to ch0, then ch3
        mode = 1'b0; sel = 2'd3; in_valid = 4'b1000;
        tick();
        check("wrap_pre_src", out_src, 2'd3);
        mode = 1'b1; in_valid = 4'b1001;
        #1;
        check("wrap_in_ready0", in_ready, 4'b0001);
        tick();
        check("wrap_src0", out_src, 2'd0);
        check("wrap_in_ready3", in_ready, 4'b1000);
        tick();
        check("wrap_src3", out_src, 2'd3);
        hold_data = 32'hA3;
        check("wrap_data3", out_data, hold_data);

        // Backpressure: three stalled cycles with changing inputs
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 4'(4'b0111 >> i) | 4'b0001;
            mode = i[0];
            sel = 2'(i);
            set_ch(0, 32'hC0 + 32'(i));
            #1;
            check("bp_in_ready", in_ready, 4'b0000);
            tick();
            check("bp_out_valid", out_valid, 1'b1);
            check("bp_out_src", out_src, 2'd3);
            check("bp_out_data", out_data, hold_data);
        end
        mode = 1'b0; sel = 2'd1; in_valid = 4'b0010; set_ch(1, 32'hCAFEF00D);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 4'b0010);
        tick();
        check("bp_new_src", out_src, 2'd1);
        check("bp_new_data", out_data, 32'hCAFEF00D);

        // Fixed sel=3 with channel 3 idle: no grant, pending word drains
        sel = 2'd3; in_valid = 4'b0111; out_ready = 1'b0;
        #1;
        check("nog_in_ready_stall", in_ready, 4'b0000);
        tick();
        check("nog_valid_held", out_valid, 1'b1);
        out_ready = 1'b1;
        #1;
        check("nog_in_ready", in_ready, 4'b0000);
        tick();
        check("nog_valid_drop", out_valid, 1'b0);
        check("nog_data_hold", out_data, 32'hCAFEF00D);
        check("nog_src_hold", out_src, 2'd1);

        // Reset while a word is held under backpressure
        sel = 2'd0; in_valid = 4'b0001; set_ch(0, 32'h12345678);
        tick();
        check("rst3_loaded", out_data, 32'h12345678);
        out_ready = 1'b0; rst = 1'b1;
        tick();
        check("rst3_out_valid", out_valid, 1'b0);
        check("rst3_out_data", out_data, 32'h0);
        check("rst3_out_src", out_src, 2'd0);
        rst = 1'b0; mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_ch(i, 32'hB0 + 32'(i));
        #1;
        check("rst3_first_ready", in_ready, 4'b0001);
        tick();
        check("rst3_first_src", out_src, 2'd0);
        check("rst3_first_data", out_data, 32'hB0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter WIDTH, default 32: data width of each channel, in bits.
REQ-002 Parameter N, default 4: number of input channels, N >= 2.
REQ-003 Parameter SEL_W, default 2: select and source-index width, equal to clog2(N).
REQ-004 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_data, input, N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port in_valid, input, N: bit i high means channel i offers data.
REQ-008 Port in_ready, output, N: bit i high means channel i is accepted this cycle.
REQ-009 Port mode, input, 1: 0 selects fixed-select mode, 1 selects round-robin mode.
REQ-010 Port sel, input, SEL_W: channel index used in fixed-select mode.
REQ-011 Port out_data, output, WIDTH: registered output data.
REQ-012 Port out_src, output, SEL_W: index of the channel that supplied out_data.
REQ-013 Port out_valid, output, 1: out_data and out_src are valid.
REQ-014 Port out_ready, input, 1: downstream consumes the output this cycle.

Function
REQ-015 The block SHALL have one output register stage, with a latency of 1 cycle from accept to out_valid.
REQ-016 load_en SHALL equal (!out_valid | out_ready); the output register SHALL update only when load_en is 1.
REQ-017 Fixed mode: the block SHALL grant channel sel when in_valid[sel]=1.
REQ-018 Fixed mode: the block SHALL grant no channel when sel >= N or in_valid[sel]=0.
REQ-019 Round-robin mode: the block SHALL grant the first valid channel found by searching upward from ptr+1 (mod N) and wrapping around.
REQ-020 The block SHALL grant at most one channel per cycle.
REQ-021 in_ready[i] SHALL equal (load_en & grant valid & grant index == i); all other in_ready bits SHALL be 0.
REQ-022 On accept, the block SHALL set out_data to in_data of the granted channel, out_src to the grant index, and out_valid to 1.
REQ-023 When load_en=1 and there is no grant, the block SHALL set out_valid to 0 and hold out_data and out_src.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_src and out_valid SHALL hold stable, and in_ready SHALL be all-zero.
REQ-025 When out_ready=1 and a new grant occur in the same cycle, the block SHALL drain the old word and load the new one, sustaining 1 word per cycle.
REQ-026 ptr SHALL update to the granted index only on an accepted transfer, in either mode.
REQ-027 A mode or sel change SHALL affect only the next grant decision and SHALL never alter a held output.
REQ-028 in_ready SHALL be combinational from in_valid, mode, sel, ptr, out_valid and out_ready, with no dependency on in_data.

Reset
REQ-029 While rst=1, the block SHALL force out_valid=0, out_data=0, out_src=0 and ptr=N-1, so that input 0 has first round-robin priority.
REQ-030 While rst=1, in_ready SHALL be all-zero.
REQ-031 Reset asserted mid-transfer SHALL discard the held word with no partial update.
REQ-032 The first grant SHALL be possible in the cycle after rst deasserts.

Verification
REQ-033 Fixed mode, sel=2, in_valid=4'b0100, in_data ch2=0xDEADBEEF, out_ready=1 -> in_ready=4'b0100; the next cycle gives out_valid=1, out_data=0xDEADBEEF, out_src=2.
REQ-034 Round-robin mode, in_valid=4'b1111 constant, out_ready=1, starting from reset -> out_src sequence 0,1,2,3,0 on consecutive cycles with out_valid continuously 1.
REQ-035 Backpressure: out_valid=1, out_ready=0 for 3 cycles while inputs change -> out_data and out_src are unchanged and in_ready=0 throughout; when out_ready=1 the new word loads the same cycle.
REQ-036 Fixed mode, sel=3, in_valid=4'b0111 -> no grant, in_ready=0, out_valid drops to 0 after the pending word is consumed.
REQ-037 Round-robin mode, ptr=3 (last grant ch3), in_valid=4'b1001 -> grant ch0 (wrap-around), then ch3.
REQ-038 rst=1 asserted while out_valid=1 with out_data=0x12345678 -> the next cycle gives out_valid=0, out_data=0, out_src=0; after deassertion the first round-robin grant is ch0.
